axi4_wch_filter: RTL and testbench
==================================

# axi4_wch_filter

Parametrised write-data-channel gate for the AXI RAB. It consumes one accept/drop decision per write burst from the address-channel translation logic and, per decision, either forwards the burst to the master port or absorbs it on the slave port. Decisions queue in a configurable-depth FIFO. Each decision carries a burst length, so the block counts beats, regenerates `m_axi4_wlast`, and reports length mismatches and completed drops to the B-channel responder. An optional output register slice is provided for timing closure.

## Interface
- `C_AXI_DATA_WIDTH`, 32: W data width; strobe width is `C_AXI_DATA_WIDTH/8`.
- `C_AXI_USER_WIDTH`, 2: wuser width.
- `C_FIFO_DEPTH`, 4: decision FIFO entries, power of two, minimum 2.
- `C_OUT_REG`, 1: 1 inserts a full-throughput skid slice on the master side; 0 makes the master side combinational.
- `axi4_aclk`  in  1  clock; the only clock.
- `axi4_arstn`  in  1  reset, asynchronous, active-low.
- `trans_accept`  in  1  burst at decision input is to be forwarded.
- `trans_drop`  in  1  burst at decision input is to be absorbed.
- `trans_len`  in  8  AXI len of the burst (beats − 1).
- `trans_ready`  out  1  decision FIFO not full.
- `s_axi4_wdata`/`wstrb`/`wlast`/`wuser`/`wvalid`  in  per params  slave W payload and valid.
- `s_axi4_wready`  out  1  slave W ready.
- `m_axi4_wdata`/`wstrb`/`wlast`/`wuser`/`wvalid`  out  per params  master W payload and valid.
- `m_axi4_wready`  in  1  master W ready.
- `drop_done`  out  1  one-cycle pulse: last beat of a dropped burst absorbed.
- `len_err`  out  1  one-cycle pulse: `s_axi4_wlast` disagreed with `trans_len`.
- `outstanding`  out  `$clog2(C_FIFO_DEPTH+1)`  number of FIFO entries.

## Operation
- **Push.** A decision is pushed when `(trans_accept|trans_drop) & trans_ready`. Entry = {accept, len}. If both `trans_accept` and `trans_drop` are high, the decision is a drop. Upstream holds the decision until `trans_ready` is high; a push while full is ignored.
- **Head-of-queue modes.**
  - EMPTY: `s_axi4_wready`=0, master `wvalid`=0.
  - FWD (head accept): `m_wvalid = s_wvalid`, `s_wready = m_wready`, or the slice's input-ready when `C_OUT_REG`=1.
  - DROP (head drop): `s_wready`=1; beats are absorbed at one per cycle.
- **Beat counting.** An 8-bit `beat_cnt` increments per slave handshake. End-of-burst `eob = s_wlast | (beat_cnt == len)`. On an `eob` handshake: pop the head and clear `beat_cnt`.
- **wlast regeneration.** Forwarded `m_axi4_wlast = eob`, so the downstream burst always terminates.
- **Length error.** `len_err` pulses on the `eob` handshake when `s_wlast != (beat_cnt == len)`.
- **Drop completion.** `drop_done` pulses on the `eob` handshake of a dropped burst.
- **Payload zeroing.** Master payload is all-zero whenever master `wvalid` is 0 (`C_OUT_REG`=0), and whenever the slice is empty (`C_OUT_REG`=1).
- **Simultaneous push and pop.**
  - Both occur in the same cycle.
  - `outstanding` is unchanged.
  - `trans_ready = !full` only; there is no pop-to-ready combinational path.

## Timing
- **Reset values.** All outputs are 0 during reset, including `trans_ready`. After release: `trans_ready`=1, `outstanding`=0, `beat_cnt`=0, skid slice empty. Reset mid-burst discards all queued decisions and the in-flight count.
- **Decision latency.** A decision pushed in cycle N becomes head in N+1; there is no fall-through. The first beat can be forwarded or absorbed in N+1.
- **Back-to-back bursts.** The pop on an `eob` in cycle M exposes the next head in M+1. Bursts therefore run back-to-back with zero bubble when the next decision is already queued.
- **Master-side latency.** `C_OUT_REG`=0 gives 0 cycles. `C_OUT_REG`=1 gives 1 cycle with 1 beat/cycle sustained and no combinational path from `m_axi4_wready` to `s_axi4_wready`.
- **Pulse timing.** `drop_done` and `len_err` are registered and asserted in the cycle after the triggering handshake.
- **Stall behaviour.** AXI rule holds: master valid/payload are stable while `m_axi4_wready`=0.

## Structure
- Shared package `axi4_rab_pkg`: entry field offsets (`DEC_ACC_BIT`, `DEC_LEN_LSB`, `DEC_LEN_W`=8).
- Sub-module `axi4_wch_skid`: 2-entry skid buffer, instantiated under a generate on `C_OUT_REG`.
- Decision FIFO: inline circular buffer with `$clog2(C_FIFO_DEPTH)`-bit pointers plus the `outstanding` counter.

## Test plan
- **Accept, len=3, wlast on beat 4, `m_wready`=1** → 4 beats forwarded; `m_wlast` only on beat 4; no pulses; `outstanding` goes 1→0.
- **Drop, len=1** → 2 beats absorbed with `s_wready`=1; `m_wvalid` stays 0; `drop_done` pulses once the cycle after beat 2.
- **Four decisions pushed back-to-back, `C_FIFO_DEPTH`=4** → `trans_ready`=0 after the 4th push; a 5th push is ignored; bursts drain with no bubble between them.
- **Accept, len=3, `s_wlast` on beat 2** → burst ends at beat 2 with `m_wlast`=1; `len_err` pulses; the next head takes over the following cycle.
- **`C_OUT_REG`=1, random `m_wready` at 50%** → data order and values preserved; 100% throughput when `m_wready`=1.
- **Reset asserted mid-burst with 3 entries queued** → all outputs are 0 immediately; after release `outstanding`=0 and `trans_ready`=1.

Source files
------------

// File: rtl/axi4_rab_pkg.sv
// Shared RAB definitions: layout of a queued write-burst decision and head-of-queue modes.
// Decision entry = {accept, len}; len is AXI len (beats - 1).
package axi4_rab_pkg;

    localparam int DEC_LEN_W   = 8;
    localparam int DEC_LEN_LSB = 0;
    localparam int DEC_ACC_BIT = DEC_LEN_LSB + DEC_LEN_W;
    localparam int DEC_W       = DEC_ACC_BIT + 1;

    typedef enum logic [1:0] {
        HEAD_EMPTY,
        HEAD_FWD,
        HEAD_DROP
    } head_mode_e;

    function automatic logic [DEC_W-1:0] dec_pack(input logic acc, input logic [DEC_LEN_W-1:0] len);
        logic [DEC_W-1:0] e;
        e = '0;
        e[DEC_ACC_BIT] = acc;
        e[DEC_LEN_LSB +: DEC_LEN_W] = len;
        return e;
    endfunction

endpackage

// File: rtl/axi4_wch_filter_if.sv
// AXI4 W channel bundle; master drives payload/valid, slave drives ready.
// Payload is only meaningful while wvalid is high.
interface axi4_wch_filter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 2
);
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic [USER_WIDTH-1:0]   wuser;
    logic                    wvalid;
    logic                    wready;

    modport master (output wdata, wstrb, wlast, wuser, wvalid, input wready);
    modport slave  (input wdata, wstrb, wlast, wuser, wvalid, output wready);
endinterface

// File: rtl/axi4_wch_skid.sv
// Two-entry skid slice: 1-cycle latency, full throughput.
// up_rdy is registered (no path from dn_rdy); dn payload reads zero while the slice is empty.
module axi4_wch_skid #(
    parameter int W = 8
) (
    input  logic         axi4_aclk,
    input  logic         axi4_arstn,
    input  logic         up_vld,
    input  logic [W-1:0] up_dat,
    output logic         up_rdy,
    output logic         dn_vld,
    output logic [W-1:0] dn_dat,
    input  logic         dn_rdy
);
    logic         main_vld;
    logic         skid_vld;
    logic [W-1:0] main_dat;
    logic [W-1:0] skid_dat;
    logic         up_hs;
    logic         main_free;

    assign up_rdy    = ~skid_vld;
    assign up_hs     = up_vld & up_rdy;
    assign main_free = ~main_vld | dn_rdy;

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_dat <= '0;
            skid_dat <= '0;
        end else if (main_free) begin
            // A parked beat always refills the output stage before new input.
            if (skid_vld) begin
                main_vld <= 1'b1;
                main_dat <= skid_dat;
                skid_vld <= 1'b0;
            end else begin
                main_vld <= up_hs;
                if (up_hs) begin
                    main_dat <= up_dat;
                end
            end
        end else if (up_hs) begin
            skid_vld <= 1'b1;
            skid_dat <= up_dat;
        end
    end

    assign dn_vld = main_vld;
    assign dn_dat = main_vld ? main_dat : '0;
endmodule

// File: rtl/axi4_wch_filter.sv
// W-channel gate: forwards or absorbs each burst per queued decision, regenerates wlast, flags length errors.
// Latency 0 (C_OUT_REG=0) or 1 (C_OUT_REG=1); decisions stall on trans_ready, beats on s_axi4.wready.
module axi4_wch_filter
    import axi4_rab_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_USER_WIDTH = 2,
    parameter int C_FIFO_DEPTH     = 4,
    parameter int C_OUT_REG        = 1
) (
    input  logic                              axi4_aclk,
    input  logic                              axi4_arstn,
    input  logic                              trans_accept,
    input  logic                              trans_drop,
    input  logic [DEC_LEN_W-1:0]              trans_len,
    output logic                              trans_ready,
    axi4_wch_filter_if.slave                  s_axi4,
    axi4_wch_filter_if.master                 m_axi4,
    output logic                              drop_done,
    output logic                              len_err,
    output logic [$clog2(C_FIFO_DEPTH+1)-1:0] outstanding
);
    localparam int PTR_W  = $clog2(C_FIFO_DEPTH);
    localparam int CNT_W  = $clog2(C_FIFO_DEPTH + 1);
    localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
    localparam int PAY_W  = C_AXI_DATA_WIDTH + STRB_W + 1 + C_AXI_USER_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(C_FIFO_DEPTH);

    logic [DEC_W-1:0]     dec_mem [C_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 rdy_q;
    logic [DEC_LEN_W-1:0] beat_cnt;
    head_mode_e           mode;
    logic                 head_acc;
    logic [DEC_LEN_W-1:0] head_len;
    logic                 push;
    logic                 pop;
    logic                 s_hs;
    logic                 len_hit;
    logic                 eob;
    logic                 fwd_rdy;
    logic                 up_vld;
    logic [PAY_W-1:0]     up_dat;

    assign push     = (trans_accept | trans_drop) & rdy_q;
    assign head_acc = dec_mem[rd_ptr][DEC_ACC_BIT];
    assign head_len = dec_mem[rd_ptr][DEC_LEN_LSB +: DEC_LEN_W];

    always_comb begin
        mode = HEAD_EMPTY;
        if (cnt_q != '0) begin
            mode = head_acc ? HEAD_FWD : HEAD_DROP;
        end
    end

    assign s_axi4.wready = (mode == HEAD_DROP) | ((mode == HEAD_FWD) & fwd_rdy);
    assign s_hs          = s_axi4.wvalid & s_axi4.wready;
    assign len_hit       = (beat_cnt == head_len);
    assign eob           = s_axi4.wlast | len_hit;
    assign pop           = s_hs & eob;
    assign cnt_nxt       = cnt_q + CNT_W'(push) - CNT_W'(pop);

    // Ready is derived from the next occupancy so it never depends on this cycle's pop.
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            rdy_q     <= 1'b0;
            beat_cnt  <= '0;
            drop_done <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt_q     <= cnt_nxt;
            rdy_q     <= (cnt_nxt != DEPTH_C);
            beat_cnt  <= pop ? '0 : (s_hs ? beat_cnt + 1'b1 : beat_cnt);
            drop_done <= pop & (mode == HEAD_DROP);
            len_err   <= pop & (s_axi4.wlast != len_hit);
        end
    end

    // A simultaneous accept+drop is stored as a drop.
    always_ff @(posedge axi4_aclk) begin
        if (push) begin
            dec_mem[wr_ptr] <= dec_pack(trans_accept & ~trans_drop, trans_len);
        end
    end

    assign trans_ready = rdy_q;
    assign outstanding = cnt_q;

    assign up_vld = (mode == HEAD_FWD) & s_axi4.wvalid;
    assign up_dat = {s_axi4.wdata, s_axi4.wstrb, eob, s_axi4.wuser};

    generate
        if (C_OUT_REG != 0) begin : g_slice
            logic [PAY_W-1:0] dn_dat;

            axi4_wch_skid #(.W(PAY_W)) u_skid (
                .axi4_aclk  (axi4_aclk),
                .axi4_arstn (axi4_arstn),
                .up_vld     (up_vld),
                .up_dat     (up_dat),
                .up_rdy     (fwd_rdy),
                .dn_vld     (m_axi4.wvalid),
                .dn_dat     (dn_dat),
                .dn_rdy     (m_axi4.wready)
            );

            assign {m_axi4.wdata, m_axi4.wstrb, m_axi4.wlast, m_axi4.wuser} = dn_dat;
        end else begin : g_comb
            assign fwd_rdy       = m_axi4.wready;
            assign m_axi4.wvalid = up_vld;
            assign {m_axi4.wdata, m_axi4.wstrb, m_axi4.wlast, m_axi4.wuser} = up_vld ? up_dat : '0;
        end
    endgenerate
endmodule

// File: tb/tb_axi4_wch_filter.sv
// Randomised bench for axi4_wch_filter (C_OUT_REG=1, depth 4) against a burst-level scoreboard.
module tb_axi4_wch_filter;
    localparam int DW = 32;
    localparam int UW = 2;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
        logic [1:0]  u;
    } beat_t;

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic       trans_accept, trans_drop;
    logic [7:0] trans_len;
    logic       trans_ready, drop_done, len_err;
    logic [2:0] outstanding;

    axi4_wch_filter_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();
    axi4_wch_filter_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();

    axi4_wch_filter #(
        .C_AXI_DATA_WIDTH (DW),
        .C_AXI_USER_WIDTH (UW),
        .C_FIFO_DEPTH     (4),
        .C_OUT_REG        (1)
    ) dut (
        .axi4_aclk    (clk),
        .axi4_arstn   (arstn),
        .trans_accept (trans_accept),
        .trans_drop   (trans_drop),
        .trans_len    (trans_len),
        .trans_ready  (trans_ready),
        .s_axi4       (s_if),
        .m_axi4       (m_if),
        .drop_done    (drop_done),
        .len_err      (len_err),
        .outstanding  (outstanding)
    );

    always #5 clk = ~clk;

    int    checks, errors, cyc;
    int    got_dd, got_le, exp_dd, exp_le;
    beat_t exp_q[$];
    beat_t got_q[$];
    bit    rdy_mode = 1'b0;
    logic  rdy_level = 1'b1;
    bit    idle_bad, stall_bad, mvld_seen, prev_stall;
    beat_t mon_b, prev_b;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        m_if.wready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_level;
    end

    // Master-side observer: records accepted beats, pulses and AXI rule breaches.
    always @(negedge clk) begin
        mon_b = {m_if.wdata, m_if.wstrb, m_if.wlast, m_if.wuser};
        if (!arstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_if.wvalid || mon_b != prev_b)) stall_bad = 1'b1;
            if (!m_if.wvalid && mon_b != '0) idle_bad = 1'b1;
            if (m_if.wvalid) mvld_seen = 1'b1;
            if (m_if.wvalid && m_if.wready) got_q.push_back(mon_b);
            if (drop_done) got_dd++;
            if (len_err) got_le++;
            prev_stall = m_if.wvalid && !m_if.wready;
            prev_b = mon_b;
        end
    end

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        got_dd = 0; got_le = 0; exp_dd = 0; exp_le = 0;
        idle_bad = 0; stall_bad = 0; mvld_seen = 0;
    endtask

    task automatic push_dec(input bit a, input bit d, input logic [7:0] l, output int pcyc);
        int n;
        n = 0;
        trans_accept = a; trans_drop = d; trans_len = l;
        @(negedge clk);
        while (!trans_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++; errors++;
            $display("FAIL push_timeout trans_ready stayed %0b, required 1", trans_ready);
        end
        pcyc = cyc;
        @(posedge clk); #1;
        trans_accept = 1'b0; trans_drop = 1'b0;
    endtask

    // Sends one burst for a decision of length len; wlast on beat w (0 = never, at most len+1).
    task automatic send_burst(input bit acc, input int len, input int w, input bit gaps,
                              output int c_first, output int c_last);
        beat_t b;
        int    k, n;
        k = (w == 0) ? len + 1 : w;
        if (!acc) exp_dd++;
        if (w != len + 1) exp_le++;
        c_first = 0; c_last = 0;
        for (int i = 0; i < k; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_if.wvalid = 1'b0;
                @(posedge clk); #1;
            end
            b.d = $urandom; b.s = 4'($urandom); b.u = 2'($urandom); b.l = (i == k - 1);
            s_if.wvalid = 1'b1; s_if.wdata = b.d; s_if.wstrb = b.s; s_if.wuser = b.u;
            s_if.wlast = (i + 1 == w);
            if (acc) exp_q.push_back(b);
            n = 0;
            @(negedge clk);
            while (!s_if.wready && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 1000) begin
                checks++; errors++;
                $display("FAIL beat_timeout s_wready stayed %0b, required 1", s_if.wready);
            end
            if (i == 0) c_first = cyc;
            c_last = cyc;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while ((got_q.size() < exp_q.size() || outstanding != 0 || m_if.wvalid) && n < 2000);
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL drain_timeout got %0d beats, required %0d", got_q.size(), exp_q.size());
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (trans_ready !== 1'b0) begin errors++; $display("FAIL rst_trans_ready got %0b exp 0", trans_ready); end
        checks++; if (s_if.wready !== 1'b0) begin errors++; $display("FAIL rst_s_wready got %0b exp 0", s_if.wready); end
        checks++; if (m_if.wvalid !== 1'b0) begin errors++; $display("FAIL rst_m_wvalid got %0b exp 0", m_if.wvalid); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_outstanding got %0d exp 0", outstanding); end
        checks++; if ({drop_done, len_err} !== 2'b00) begin errors++; $display("FAIL rst_pulses got %b exp 00", {drop_done, len_err}); end
        @(posedge clk); #1;
        arstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (trans_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %0b exp 1", trans_ready); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL post_rst_outstanding got %0d exp 0", outstanding); end
        checks++; if (s_if.wready !== 1'b0) begin errors++; $display("FAIL post_rst_s_wready got %0b exp 0", s_if.wready); end
        @(posedge clk); #1;
    endtask

    task automatic test_accept();
        int pc, f, l;
        clear_sb();
        push_dec(1'b1, 1'b0, 8'd3, pc);
        @(negedge clk);
        checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL acc_outstanding_1 got %0d exp 1", outstanding); end
        @(posedge clk); #1;
        send_burst(1'b1, 3, 4, 1'b0, f, l);
        wait_drain();
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL acc_beats got %0d exp 4", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL acc_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (l - f != 3) begin errors++; $display("FAIL acc_rate got %0d cycles exp 3", l - f); end
        checks++; if ({got_dd, got_le} != 0) begin errors++; $display("FAIL acc_pulses got dd=%0d le=%0d exp 0", got_dd, got_le); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL acc_outstanding_0 got %0d exp 0", outstanding); end
    endtask

    task automatic test_drop();
        int pc, f, l;
        clear_sb();
        push_dec(1'b0, 1'b1, 8'd1, pc);
        send_burst(1'b0, 1, 2, 1'b0, f, l);
        s_if.wvalid = 1'b0;
        @(negedge clk);
        checks++; if (drop_done !== 1'b1) begin errors++; $display("FAIL drop_pulse got %0b exp 1", drop_done); end
        @(negedge clk);
        checks++; if (drop_done !== 1'b0) begin errors++; $display("FAIL drop_pulse_end got %0b exp 0", drop_done); end
        checks++; if (l - f != 1) begin errors++; $display("FAIL drop_rate got %0d exp 1", l - f); end
        @(posedge clk); #1;
        // accept and drop together must be treated as a drop
        push_dec(1'b1, 1'b1, 8'd0, pc);
        send_burst(1'b0, 0, 1, 1'b0, f, l);
        wait_drain();
        checks++; if (mvld_seen !== 1'b0) begin errors++; $display("FAIL drop_m_wvalid got %0b exp 0", mvld_seen); end
        checks++; if (got_dd != exp_dd) begin errors++; $display("FAIL drop_count got %0d exp %0d", got_dd, exp_dd); end
        checks++; if (got_le != 0) begin errors++; $display("FAIL drop_len_err got %0d exp 0", got_le); end
    endtask

    task automatic test_back_to_back();
        int pc, f, l, first, last, total;
        bit acc[4];
        int len[4];
        clear_sb();
        total = 0;
        for (int i = 0; i < 4; i++) begin
            acc[i] = 1'($urandom_range(0, 1));
            len[i] = $urandom_range(0, 3);
            total += len[i] + 1;
            push_dec(acc[i], !acc[i], 8'(len[i]), pc);
        end
        @(negedge clk);
        checks++; if (trans_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", trans_ready); end
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_outstanding got %0d exp 4", outstanding); end
        @(posedge clk); #1;
        trans_accept = 1'b1; trans_len = 8'd0;
        repeat (2) @(posedge clk);
        #1 trans_accept = 1'b0;
        @(negedge clk);
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL push_while_full got %0d exp 4", outstanding); end
        @(posedge clk); #1;
        first = 0; last = 0;
        for (int i = 0; i < 4; i++) begin
            send_burst(acc[i], len[i], len[i] + 1, 1'b0, f, l);
            if (i == 0) first = f;
            last = l;
        end
        wait_drain();
        checks++; if (last - first + 1 != total) begin errors++; $display("FAIL b2b_cycles got %0d exp %0d", last - first + 1, total); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_beats got %0d exp %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (got_dd != exp_dd) begin errors++; $display("FAIL b2b_drop_done got %0d exp %0d", got_dd, exp_dd); end
        checks++; if (got_le != 0) begin errors++; $display("FAIL b2b_len_err got %0d exp 0", got_le); end
    endtask

    task automatic test_len_err();
        int pc1, pc2, f1, l1, f2, l2;
        clear_sb();
        fork
            begin
                push_dec(1'b1, 1'b0, 8'd3, pc1);
                push_dec(1'b1, 1'b0, 8'd1, pc2);
            end
            begin
                send_burst(1'b1, 3, 2, 1'b0, f1, l1);
                send_burst(1'b1, 1, 2, 1'b0, f2, l2);
            end
        join
        wait_drain();
        checks++; if (f1 != pc1 + 1) begin errors++; $display("FAIL dec_latency got %0d exp %0d", f1 - pc1, 1); end
        checks++; if (f2 != l1 + 1) begin errors++; $display("FAIL next_head got %0d exp %0d", f2 - l1, 1); end
        checks++; if (got_le != exp_le) begin errors++; $display("FAIL len_err_count got %0d exp %0d", got_le, exp_le); end
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL lerr_beats got %0d exp 4", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL lerr_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        localparam int N = 20;
        bit pa[N], pd[N];
        int pl[N], pw[N];
        clear_sb();
        for (int i = 0; i < N; i++) begin
            pa[i] = 1'($urandom_range(0, 1));
            pd[i] = pa[i] ? ($urandom_range(0, 3) == 0) : 1'b1;
            pl[i] = $urandom_range(0, 7);
            pw[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, pl[i] + 1) : pl[i] + 1;
        end
        rdy_mode = 1'b1;
        fork
            begin
                int pc;
                for (int i = 0; i < N; i++) begin
                    push_dec(pa[i], pd[i], 8'(pl[i]), pc);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
            begin
                int f, l;
                for (int i = 0; i < N; i++) send_burst(pa[i] & !pd[i], pl[i], pw[i], 1'b1, f, l);
            end
        join
        wait_drain();
        rdy_mode = 1'b0;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_beats got %0d exp %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (got_dd != exp_dd) begin errors++; $display("FAIL rnd_drop_done got %0d exp %0d", got_dd, exp_dd); end
        checks++; if (got_le != exp_le) begin errors++; $display("FAIL rnd_len_err got %0d exp %0d", got_le, exp_le); end
        checks++; if (stall_bad) begin errors++; $display("FAIL rnd_stall_stable got 1 exp 0"); end
        checks++; if (idle_bad) begin errors++; $display("FAIL rnd_idle_zero got 1 exp 0"); end
    endtask

    task automatic test_reset_mid();
        int pc, f, l;
        clear_sb();
        rdy_level = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) push_dec(1'b1, 1'b0, 8'd3, pc);
        for (int i = 0; i < 3; i++) begin
            s_if.wvalid = 1'b1; s_if.wdata = $urandom; s_if.wstrb = 4'hf; s_if.wuser = 2'd1; s_if.wlast = 1'b0;
            @(posedge clk); #1;
        end
        arstn = 1'b0;
        #1;
        checks++; if (trans_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %0b exp 0", trans_ready); end
        checks++; if (s_if.wready !== 1'b0) begin errors++; $display("FAIL mid_rst_s_wready got %0b exp 0", s_if.wready); end
        checks++; if (m_if.wvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_m_wvalid got %0b exp 0", m_if.wvalid); end
        checks++; if (m_if.wdata !== 32'd0) begin errors++; $display("FAIL mid_rst_m_wdata got %h exp 0", m_if.wdata); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL mid_rst_outstanding got %0d exp 0", outstanding); end
        s_if.wvalid = 1'b0;
        @(posedge clk); #1;
        arstn = 1'b1;
        rdy_level = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (trans_ready !== 1'b1) begin errors++; $display("FAIL mid_post_ready got %0b exp 1", trans_ready); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL mid_post_outstanding got %0d exp 0", outstanding); end
        @(posedge clk); #1;
        clear_sb();
        push_dec(1'b1, 1'b0, 8'd1, pc);
        send_burst(1'b1, 1, 2, 1'b0, f, l);
        wait_drain();
        checks++; if (got_le != 0) begin errors++; $display("FAIL mid_recover_len_err got %0d exp 0", got_le); end
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL mid_recover_beats got %0d exp 2", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_recover_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        trans_accept = 1'b0; trans_drop = 1'b0; trans_len = 8'd0;
        s_if.wvalid = 1'b0; s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0; s_if.wuser = '0;
        clear_sb();
        test_reset();
        test_accept();
        test_drop();
        test_back_to_back();
        test_len_err();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not complete, checks %0d", checks);
        $fatal(1);
    end
endmodule
